controle_pc: RTL and testbench



---
 rtl/pc_ctrl_pkg.sv | 69 ++++++
 rtl/decod_instr.sv | 28 ++
 rtl/controle_pc.sv | 161 ++++++++++++++++
 tb/tb_controle_pc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the program-counter sequencer: states, PCSource selects,
// exception codes and the opcode/funct values the decoder recognises.
package pc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_F0        = 4'd1,
      S_F1        = 4'd2,
      S_F2        = 4'd3,
      S_DECODE    = 4'd4,
      S_BRANCH    = 4'd5,
      S_JUMP      = 4'd6,
      S_JR        = 4'd7,
      S_RTE       = 4'd8,
      S_EXEC_WAIT = 4'd9,
      S_EXC0      = 4'd10,
      S_EXC1      = 4'd11,
      S_EXC2      = 4'd12
   } state_t;

   localparam logic [2:0] PCS_ALU    = 3'b000;
   localparam logic [2:0] PCS_ALUOUT = 3'b001;
   localparam logic [2:0] PCS_JUMP   = 3'b010;
   localparam logic [2:0] PCS_EPC    = 3'b011;
   localparam logic [2:0] PCS_EXC    = 3'b100;
   localparam logic [2:0] PCS_RS     = 3'b101;

   localparam logic [1:0] EXC_NONE   = 2'b00;
   localparam logic [1:0] EXC_OPCODE = 2'b01;
   localparam logic [1:0] EXC_OVF    = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_RTE = 6'h13;

   localparam int NUM_VALID_OPS = 15;
   localparam logic [5:0] VALID_OPCODES [NUM_VALID_OPS] = '{
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_LUI, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW
   };

   // Any opcode outside this list is trapped as an illegal instruction.
   function automatic logic isValidOpcode(input logic [5:0] op);
      logic found;
      found = 1'b0;
      for (int k = 0; k < NUM_VALID_OPS; k++) begin
         if (VALID_OPCODES[k] == op) begin
            found = 1'b1;
         end
      end
      return found;
   endfunction

endpackage

// File: rtl/decod_instr.sv
// Combinational instruction classifier: tells the sequencer which PC-changing
// class an opcode/funct pair belongs to and whether the opcode is legal at all.
module decod_instr
   import pc_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic       o_isBranch,
   output logic       o_isJump,
   output logic       o_isJr,
   output logic       o_isRte,
   output logic       o_isValid
);

   logic w_isRtype;

   assign w_isRtype = (i_opcode == OP_RTYPE);

   // jr and rte are R-type sub-cases; every other funct is delegated work.
   always_comb begin
      o_isBranch = (i_opcode == OP_BEQ) || (i_opcode == OP_BNE);
      o_isJump   = (i_opcode == OP_J)   || (i_opcode == OP_JAL);
      o_isJr     = w_isRtype && (i_funct == FN_JR);
      o_isRte    = w_isRtype && (i_funct == FN_RTE);
      o_isValid  = isValidOpcode(i_opcode);
   end

endmodule

// File: rtl/controle_pc.sv
// Multicycle PC-path sequencer: fetch, decode, PC-changing instructions and
// exception entry; everything else is handed to main control via start/done.
module controle_pc
   import pc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   input  logic       instr_done,
   output logic [2:0] pc_source,
   output logic       pc_write,
   output logic       ir_write,
   output logic       epc_write,
   output logic [1:0] exc_vec_sel,
   output logic       start_exec,
   output logic [3:0] state_o
);

   state_t     r_state;
   state_t     w_nextState;
   logic [1:0] r_excCode;
   logic [1:0] w_excCodeNext;
   logic       w_loadExc;

   logic w_isBranch;
   logic w_isJump;
   logic w_isJr;
   logic w_isRte;
   logic w_isValid;

   decod_instr u_decod (
      .i_opcode   (opcode),
      .i_funct    (funct),
      .o_isBranch (w_isBranch),
      .o_isJump   (w_isJump),
      .o_isJr     (w_isJr),
      .o_isRte    (w_isRte),
      .o_isValid  (w_isValid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The code survives EXC0..EXC2 so the vector address stays stable across the memory wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_excCode <= EXC_NONE;
      end else if (w_loadExc) begin
         r_excCode <= w_excCodeNext;
      end else if (r_state == S_F0) begin
         r_excCode <= EXC_NONE;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_loadExc     = 1'b0;
      w_excCodeNext = EXC_NONE;
      case (r_state)
         S_RESET: w_nextState = S_F0;
         S_F0:    w_nextState = S_F1;
         S_F1:    w_nextState = S_F2;
         S_F2:    w_nextState = S_DECODE;
         S_DECODE: begin
            if (!w_isValid) begin
               w_nextState   = S_EXC0;
               w_loadExc     = 1'b1;
               w_excCodeNext = EXC_OPCODE;
            end else if (w_isBranch) begin
               w_nextState = S_BRANCH;
            end else if (w_isJump) begin
               w_nextState = S_JUMP;
            end else if (w_isJr) begin
               w_nextState = S_JR;
            end else if (w_isRte) begin
               w_nextState = S_RTE;
            end else begin
               w_nextState = S_EXEC_WAIT;
            end
         end
         S_BRANCH: w_nextState = S_F0;
         S_JUMP:   w_nextState = S_F0;
         S_JR:     w_nextState = S_F0;
         S_RTE:    w_nextState = S_F0;
         S_EXEC_WAIT: begin
            // Overflow wins over a simultaneous done: the result must not be committed.
            if (overflow) begin
               w_nextState   = S_EXC0;
               w_loadExc     = 1'b1;
               w_excCodeNext = EXC_OVF;
            end else if (instr_done) begin
               w_nextState = S_F0;
            end
         end
         S_EXC0:  w_nextState = S_EXC1;
         S_EXC1:  w_nextState = S_EXC2;
         S_EXC2:  w_nextState = S_F0;
         default: w_nextState = S_RESET;
      endcase
   end

   always_comb begin
      pc_source   = PCS_ALU;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      epc_write   = 1'b0;
      exc_vec_sel = EXC_NONE;
      start_exec  = 1'b0;
      case (r_state)
         S_F2: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            start_exec = w_isValid && !w_isBranch && !w_isJump && !w_isJr && !w_isRte;
         end
         S_BRANCH: begin
            pc_source = PCS_ALUOUT;
            pc_write  = (opcode == OP_BNE) ? ~zero : zero;
         end
         S_JUMP: begin
            pc_source = PCS_JUMP;
            pc_write  = 1'b1;
         end
         S_JR: begin
            pc_source = PCS_RS;
            pc_write  = 1'b1;
         end
         S_RTE: begin
            pc_source = PCS_EPC;
            pc_write  = 1'b1;
         end
         S_EXC0: begin
            epc_write   = 1'b1;
            exc_vec_sel = r_excCode;
         end
         S_EXC1: begin
            exc_vec_sel = r_excCode;
         end
         S_EXC2: begin
            exc_vec_sel = r_excCode;
            pc_source   = PCS_EXC;
            pc_write    = 1'b1;
         end
         default: begin
            pc_source = PCS_ALU;
         end
      endcase
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_controle_pc.sv
// Directed bench for controle_pc: an instruction-level model expands each
// instruction into its expected cycle trace, which is checked every cycle.
module tb_controle_pc;
   import pc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       instr_done;
   logic [2:0] pc_source;
   logic       pc_write;
   logic       ir_write;
   logic       epc_write;
   logic [1:0] exc_vec_sel;
   logic       start_exec;
   logic [3:0] state_o;

   controle_pc dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .overflow    (overflow),
      .instr_done  (instr_done),
      .pc_source   (pc_source),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .epc_write   (epc_write),
      .exc_vec_sel (exc_vec_sel),
      .start_exec  (start_exec),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       rstMid;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       ov;
      logic       dn;
      logic [3:0] st;
      logic [2:0] src;
      logic       pcw;
      logic       irw;
      logic       epcw;
      logic [1:0] vec;
      logic       se;
   } cycle_t;

   cycle_t q[$];
   logic [5:0] curOp;
   logic [5:0] curFn;

   int nVectors  = 0;
   int nMiscomp  = 0;
   int pcwCount  = 0;
   int seCount   = 0;
   int latIdx    = 0;
   int lastF0    = -1;
   int expLat [12] = '{5, 5, 5, 5, 5, 5, 5, 7, 8, 6, 7, 5};

   task automatic addCycle(input logic [3:0] st, input logic [2:0] src, input logic pcw,
                           input logic irw, input logic epcw, input logic [1:0] vec,
                           input logic se, input logic z, input logic ov, input logic dn,
                           input logic rst, input logic rstMid);
      cycle_t c;
      c.rst = rst; c.rstMid = rstMid; c.op = curOp; c.fn = curFn;
      c.z = z; c.ov = ov; c.dn = dn;
      c.st = st; c.src = src; c.pcw = pcw; c.irw = irw; c.epcw = epcw;
      c.vec = vec; c.se = se;
      q.push_back(c);
   endtask

   // Exception entry trace; overflow/done driven high to show they are ignored here.
   task automatic addExc(input logic [1:0] code);
      addCycle(S_EXC0, 3'd0, 1'b0, 1'b0, 1'b1, code, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_EXC1, 3'd0, 1'b0, 1'b0, 1'b0, code, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_EXC2, 3'd4, 1'b1, 1'b0, 1'b0, code, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic addFetch(input logic se);
      addCycle(S_F0,     3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_F1,     3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_F2,     3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_DECODE, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, se,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Expands one instruction into the cycle trace the instruction-set rules demand.
   task automatic addInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int nWait, input logic ovfLast);
      logic isBr, isJ, isJr, isRte, valid, deleg;
      curOp = op; curFn = fn;
      isBr  = (op == 6'h04) || (op == 6'h05);
      isJ   = (op == 6'h02) || (op == 6'h03);
      isJr  = (op == 6'h00) && (fn == 6'h08);
      isRte = (op == 6'h00) && (fn == 6'h13);
      valid = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C,
                         6'h0F, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
      deleg = valid && !isBr && !isJ && !isJr && !isRte;
      addFetch(deleg);
      if (!valid) begin
         addExc(2'b01);
      end else if (isBr) begin
         addCycle(S_BRANCH, 3'd1, (op == 6'h04) ? z : ~z, 1'b0, 1'b0, 2'd0, 1'b0,
                  z, 1'b1, 1'b1, 1'b0, 1'b0);
      end else if (isJ) begin
         addCycle(S_JUMP, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      end else if (isJr) begin
         addCycle(S_JR, 3'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      end else if (isRte) begin
         addCycle(S_RTE, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
         for (int w = 1; w <= nWait; w++) begin
            addCycle(S_EXEC_WAIT, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1,
                     (w == nWait) ? ovfLast : 1'b0, (w == nWait), 1'b0, 1'b0);
         end
         if (ovfLast) begin
            addExc(2'b10);
         end
      end
   endtask

   task automatic addReset(input int n);
      for (int k = 0; k < n; k++) begin
         addCycle(S_RESET, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      addCycle(S_RESET, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic applyStimulus(input cycle_t c);
      @(posedge clk);
      #1;
      reset      = c.rst;
      opcode     = c.op;
      funct      = c.fn;
      zero       = c.z;
      overflow   = c.ov;
      instr_done = c.dn;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscomp++;
         $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   initial begin
      logic [3:0] prevSt;
      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; instr_done = 1'b0;
      curOp = '0; curFn = '0;

      addReset(3);
      addInstr(6'h04, 6'h00, 1'b1, 0, 1'b0);
      addInstr(6'h04, 6'h00, 1'b0, 0, 1'b0);
      addInstr(6'h05, 6'h00, 1'b0, 0, 1'b0);
      addInstr(6'h02, 6'h00, 1'b1, 0, 1'b0);
      addInstr(6'h03, 6'h00, 1'b1, 0, 1'b0);
      addInstr(6'h00, 6'h08, 1'b1, 0, 1'b0);
      addInstr(6'h00, 6'h13, 1'b1, 0, 1'b0);
      addInstr(6'h23, 6'h00, 1'b1, 3, 1'b0);
      addInstr(6'h00, 6'h20, 1'b1, 1, 1'b1);
      addInstr(6'h08, 6'h00, 1'b1, 2, 1'b0);
      addInstr(6'h3F, 6'h00, 1'b1, 0, 1'b0);
      addInstr(6'h2B, 6'h00, 1'b1, 1, 1'b0);
      // Illegal opcode cut short by reset in the middle of EXC1.
      curOp = 6'h3F; curFn = 6'h00;
      addFetch(1'b0);
      addCycle(S_EXC0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      addCycle(S_EXC1, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      addReset(1);
      addInstr(6'h04, 6'h00, 1'b1, 0, 1'b0);

      prevSt = S_RESET;
      for (int i = 0; i < q.size(); i++) begin
         applyStimulus(q[i]);
         @(negedge clk);
         checkOutput("state_o",     {4'd0, state_o},     {4'd0, q[i].st});
         checkOutput("pc_source",   {5'd0, pc_source},   {5'd0, q[i].src});
         checkOutput("pc_write",    {7'd0, pc_write},    {7'd0, q[i].pcw});
         checkOutput("ir_write",    {7'd0, ir_write},    {7'd0, q[i].irw});
         checkOutput("epc_write",   {7'd0, epc_write},   {7'd0, q[i].epcw});
         checkOutput("exc_vec_sel", {6'd0, exc_vec_sel}, {6'd0, q[i].vec});
         checkOutput("start_exec",  {7'd0, start_exec},  {7'd0, q[i].se});
         if (pc_write === 1'b1) pcwCount++;
         if (start_exec === 1'b1) seCount++;
         if (state_o == S_F0 && prevSt != S_F0) begin
            if (lastF0 >= 0 && latIdx < 12) begin
               checkOutput("fetch_latency", 8'(i - lastF0), 8'(expLat[latIdx]));
               latIdx++;
            end
            lastF0 = i;
         end
         prevSt = state_o;
         if (q[i].rstMid) begin
            reset = 1'b1;
            #1;
            checkOutput("async_rst_state", {4'd0, state_o}, 8'd0);
            checkOutput("async_rst_outs",
                        {pc_source, pc_write, ir_write, epc_write, exc_vec_sel}, 8'd0);
            checkOutput("async_rst_start", {7'd0, start_exec}, 8'd0);
         end
      end

      // Hand-counted totals over the whole directed sequence.
      checkOutput("latencies_seen", 8'(latIdx), 8'd12);
      checkOutput("start_pulses",   8'(seCount), 8'd4);
      checkOutput("pc_write_cycles", 8'(pcwCount), 8'd23);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscomp);
      $finish;
   end

endmodule
